calc_operand_sequencer: RTL and testbench

- Front-end stage that feeds the 4-bit calculator core.
- Collects operand A, operand B and the 2-bit opcode in turn from shared switches. Each value is captured by one press of a single debounced "enter" button.
- When all three are captured, presents them stably and pulses `go` for one cycle so the calculator registers a fresh result.
- Drives a step indicator so the user knows which value the next press captures.

---
 rtl/calc_operand_sequencer_if.sv | 24 ++
 rtl/calc_operand_sequencer.sv | 99 +++++++++
 tb/tb_calc_operand_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_operand_sequencer_if.sv
// Switch/button inputs and captured-operand outputs shared between the
// operand sequencer and whatever drives it.
interface calc_operand_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic [1:0]       op_sw;
    logic             enter_btn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             go;
    logic [1:0]       step;

    modport master (
        output sw, op_sw, enter_btn,
        input  a, b, op, go, step
    );

    modport slave (
        input  sw, op_sw, enter_btn,
        output a, b, op, go, step
    );
endinterface

// File: rtl/calc_operand_sequencer.sv
// Collects operand A, operand B and the opcode from shared switches, one
// debounced button press each, then strobes go for one cycle.
module calc_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                       clock,
    input logic                       clear,
    calc_operand_sequencer_if.slave   bus
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] LOAD_A  = 2'd0;
    localparam logic [1:0] LOAD_B  = 2'd1;
    localparam logic [1:0] LOAD_OP = 2'd2;
    localparam logic [1:0] FIRE    = 2'd3;

    logic             s1;
    logic             s2;
    logic             db_level;
    logic             db_q;
    logic [CNT_W-1:0] db_cnt;
    logic             press;
    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.enter_btn;
            s2 <= s1;
        end
    end

    // The level only flips once s2 has disagreed with it for DEBOUNCE_CYCLES
    // consecutive samples; any agreement restarts the count.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            db_q     <= 1'b0;
        end else begin
            db_q <= db_level;
            if (s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                db_level <= ~db_level;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db_level & ~db_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= LOAD_A;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press) begin
                        a_reg <= bus.sw;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_reg <= bus.sw;
                        state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (press) begin
                        op_reg <= bus.op_sw;
                        state  <= FIRE;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    // go comes straight off the state register so it never glitches on inputs.
    assign bus.go   = (state == FIRE);
    assign bus.step = state;
    assign bus.a    = a_reg;
    assign bus.b    = b_reg;
    assign bus.op   = op_reg;
endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer: table of full presses, hand-built corner
// sequences, and random button activity against a sample-window model.
module tb_calc_operand_sequencer;
    localparam int WIDTH = 4;
    localparam int DEB   = 4;
    localparam int HOLD  = DEB + 4;

    typedef struct {
        logic [3:0] sw;
        logic [1:0] op_sw;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [1:0] exp_op;
        logic [1:0] exp_step;
        int         exp_go;
    } vec_t;

    logic clock = 1'b0;
    logic clear = 1'b0;

    calc_operand_sequencer_if #(.WIDTH(WIDTH)) bus();

    calc_operand_sequencer #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int   vectors     = 0;
    int   miscompares = 0;
    int   go_seen     = 0;
    vec_t tbl[6];

    // Model state: every button value presented at an edge since reset.
    bit         hist[$];
    logic       m_level;
    logic       m_press;
    logic [1:0] m_step;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [1:0] m_op;

    function automatic logic [12:0] dut_view();
        return {bus.a, bus.b, bus.op, bus.go, bus.step};
    endfunction

    function automatic logic [12:0] model_view();
        return {m_a, m_b, m_op, (m_step == 2'd3), m_step};
    endfunction

    // Button value the debouncer sees at edge j, two edges behind the pin.
    function automatic bit seen(input int j);
        if (j < 2) return 1'b0;
        return hist[j-2];
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_level = 1'b0;
        m_press = 1'b0;
        m_step  = 2'd0;
        m_a     = 4'd0;
        m_b     = 4'd0;
        m_op    = 2'd0;
    endtask

    task automatic model_edge(input logic btn, input logic [3:0] swv, input logic [1:0] opv);
        int k;
        bit all_diff;
        if (m_step == 2'd3) begin
            m_step = 2'd0;
        end else if (m_press) begin
            case (m_step)
                2'd0:    m_a  = swv;
                2'd1:    m_b  = swv;
                default: m_op = opv;
            endcase
            m_step = m_step + 2'd1;
        end
        hist.push_back(btn);
        k = hist.size() - 1;
        all_diff = 1'b1;
        for (int j = k - DEB + 1; j <= k; j++)
            if (seen(j) == m_level) all_diff = 1'b0;
        m_press = 1'b0;
        if (all_diff) begin
            m_level = ~m_level;
            m_press = m_level;
        end
    endtask

    task automatic apply_stimulus(input logic btn, input logic [3:0] swv, input logic [1:0] opv);
        bus.enter_btn = btn;
        bus.sw        = swv;
        bus.op_sw     = opv;
        @(posedge clock);
        #1;
        model_edge(btn, swv, opv);
        if (bus.go) go_seen++;
        check_output("cycle", dut_view(), model_view());
    endtask

    task automatic press(input logic [3:0] swv, input logic [1:0] opv);
        repeat (HOLD) apply_stimulus(1'b1, swv, opv);
        repeat (HOLD) apply_stimulus(1'b0, swv, opv);
    endtask

    // Clear lands between edges so the zeroed outputs prove it is asynchronous.
    task automatic apply_reset();
        clear = 1'b1;
        #1;
        check_output("async_reset", dut_view(), 32'd0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        bus.enter_btn = 1'b0;
        bus.sw        = 4'd0;
        bus.op_sw     = 2'd0;
        model_reset();

        tbl[0] = '{4'h3, 2'b00, 4'h3, 4'h0, 2'b00, 2'd1, 0};
        tbl[1] = '{4'h5, 2'b00, 4'h3, 4'h5, 2'b00, 2'd2, 0};
        tbl[2] = '{4'h0, 2'b01, 4'h3, 4'h5, 2'b01, 2'd0, 1};
        tbl[3] = '{4'hC, 2'b11, 4'hC, 4'h5, 2'b01, 2'd1, 0};
        tbl[4] = '{4'h6, 2'b11, 4'hC, 4'h6, 2'b01, 2'd2, 0};
        tbl[5] = '{4'hF, 2'b10, 4'hC, 4'h6, 2'b10, 2'd0, 1};

        #2;
        apply_reset();
        foreach (tbl[i]) begin
            go_seen = 0;
            press(tbl[i].sw, tbl[i].op_sw);
            check_output("tbl_a",    bus.a,    tbl[i].exp_a);
            check_output("tbl_b",    bus.b,    tbl[i].exp_b);
            check_output("tbl_op",   bus.op,   tbl[i].exp_op);
            check_output("tbl_step", bus.step, tbl[i].exp_step);
            check_output("tbl_go",   go_seen,  tbl[i].exp_go);
        end

        // Held button: exactly one capture at edge DEB+2, nothing on release.
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 4'h8, 2'b00);
            check_output("held_step", bus.step, (i >= DEB + 2) ? 1 : 0);
        end
        repeat (20) apply_stimulus(1'b0, 4'h1, 2'b00);
        check_output("held_release_step", bus.step, 1);
        check_output("held_a", bus.a, 4'h8);

        apply_reset();
        for (int i = 0; i < 10; i++)
            apply_stimulus((i % 2) == 0, 4'h2, 2'b00);
        for (int i = 10; i < 20; i++) begin
            apply_stimulus(1'b1, 4'h2, 2'b00);
            check_output("bounce_step", bus.step, (i >= 10 + DEB + 2) ? 1 : 0);
        end

        apply_reset();
        repeat (2) apply_stimulus(1'b1, 4'h9, 2'b00);
        repeat (20) apply_stimulus(1'b0, 4'h9, 2'b00);
        check_output("glitch_step", bus.step, 0);
        check_output("glitch_a", bus.a, 0);

        apply_reset();
        press(4'h9, 2'b00);
        press(4'h2, 2'b00);
        check_output("midop_step", bus.step, 2);
        check_output("midop_ab", {bus.a, bus.b}, 8'h92);
        apply_reset();
        go_seen = 0;
        press(4'h1, 2'b00);
        press(4'h2, 2'b00);
        press(4'h0, 2'b11);
        check_output("fresh_go", go_seen, 1);
        check_output("fresh_view", dut_view(), {4'h1, 4'h2, 2'b11, 1'b0, 2'd0});

        apply_reset();
        for (int i = 0; i < 10; i++)
            apply_stimulus(1'b1, (i < 3) ? 4'hA : 4'h7, 2'b00);
        check_output("late_sw_a", bus.a, 4'h7);

        bus.enter_btn = 1'b1;
        apply_reset();
        repeat (HOLD) apply_stimulus(1'b1, 4'h4, 2'b00);
        check_output("held_reset_a", bus.a, 4'h4);
        check_output("held_reset_step", bus.step, 1);
        repeat (HOLD) apply_stimulus(1'b0, 4'h4, 2'b00);

        for (int r = 0; r < 150; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            repeat (len) apply_stimulus(lvl, 4'($urandom), 2'($urandom));
            if (r == 75) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
